// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the CPU MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory target: one outstanding load/store, ack exactly LATENCY cycles after accept.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          LAT_ONE    = (LATENCY == 1);
    localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
    localparam logic [DW-1:0] ADDR_LIMIT = DW'(4 * DEPTH);

    // Configuration sanity checks
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_mem_responder: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_ready;
    logic            r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic            r_busy;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_idle;
    logic            w_accept;
    logic            w_sel_we;
    logic [DW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [AW-1:0]   w_index;
    logic            w_err;
    logic            w_enter_resp;
    logic            w_commit;
    logic [DW-1:0]   w_resp_rdata;

    // With LATENCY=1 the response edge is the accept edge, so the live bus is used instead of the latch
    always_comb begin
        w_idle      = (r_state == ST_IDLE);
        w_accept    = w_idle & bus.req_i;
        w_sel_we    = w_idle ? bus.we_i    : r_we;
        w_sel_addr  = w_idle ? bus.addr_i  : r_addr;
        w_sel_wdata = w_idle ? bus.wdata_i : r_wdata;
    end

    // Address legality and word index of the request being answered
    always_comb begin
        w_index = w_sel_addr[AW+1:2];
        w_err   = (w_sel_addr[1:0] != 2'b00) | (w_sel_addr >= ADDR_LIMIT);
    end

    // Edge that moves the FSM into RESP, and whether it commits a store
    always_comb begin
        w_enter_resp = (w_accept & LAT_ONE) | ((r_state == ST_WAIT) & (r_cnt == '0));
        w_commit     = w_enter_resp & w_sel_we & ~w_err & ~rst_i;
        w_resp_rdata = (w_sel_we | w_err) ? '0 : r_mem[w_index];
    end

    // Data array; never cleared, writes only on a committing store
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            r_mem[w_index] <= w_sel_wdata;
        end
    end

    // Request FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        r_we    <= bus.we_i;
                        r_addr  <= bus.addr_i;
                        r_wdata <= bus.wdata_i;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (LAT_ONE) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_err;
                            r_rdata <= w_resp_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_err;
                        r_rdata <= w_resp_rdata;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus from the output registers
    assign bus.ready_o = r_ready;
    assign bus.ack_o   = r_ack;
    assign bus.rdata_o = r_rdata;
    assign bus.err_o   = r_err;
    assign bus.busy_o  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one LATENCY=3 instance and one LATENCY=1 instance against a word-array model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [31:0] model_a [32];
    logic [31:0] model_b [32];

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH(32), .LATENCY(3)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    data_mem_responder #(.DEPTH(32), .LATENCY(1)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd128);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom % 8;
        if (r < 5)       return 32'(($urandom % 32) * 4);
        else if (r == 5) return 32'(($urandom % 32) * 4 + 1 + ($urandom % 3));
        else if (r == 6) return 32'(128 + ($urandom % 64));
        else             return $urandom;
    endfunction

    task automatic idle_a(input string tag);
        chk1({tag, "_ready"}, bus_a.ready_o, 1'b1);
        chk1({tag, "_ack"},   bus_a.ack_o,   1'b0);
        chk1({tag, "_busy"},  bus_a.busy_o,  1'b0);
        chk32({tag, "_rdata"}, bus_a.rdata_o, 32'h0);
        chk1({tag, "_err"},   bus_a.err_o,   1'b0);
    endtask

    task automatic idle_b(input string tag);
        chk1({tag, "_ready"}, bus_b.ready_o, 1'b1);
        chk1({tag, "_ack"},   bus_b.ack_o,   1'b0);
        chk1({tag, "_busy"},  bus_b.busy_o,  1'b0);
        chk32({tag, "_rdata"}, bus_b.rdata_o, 32'h0);
        chk1({tag, "_err"},   bus_b.err_o,   1'b0);
    endtask

    // One LATENCY=3 transaction; optionally scrambles the bus while the request is in flight
    task automatic txn_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit scramble);
        logic [31:0] exp_rdata;
        bit          exp_err;
        exp_err   = addr_bad(addr);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) model_a[int'(addr / 4)] = wdata;
            else    exp_rdata = model_a[int'(addr / 4)];
        end
        chk1("a_ready_pre", bus_a.ready_o, 1'b1);
        bus_a.req_i   = 1'b1;
        bus_a.we_i    = we;
        bus_a.addr_i  = addr;
        bus_a.wdata_i = wdata;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                chk1("a_wait_ack",   bus_a.ack_o,   1'b0);
                chk1("a_wait_ready", bus_a.ready_o, 1'b0);
                chk1("a_wait_busy",  bus_a.busy_o,  1'b1);
            end else begin
                chk1("a_resp_ack",    bus_a.ack_o,   1'b1);
                chk1("a_resp_err",    bus_a.err_o,   exp_err);
                chk32("a_resp_rdata", bus_a.rdata_o, exp_rdata);
                chk1("a_resp_ready",  bus_a.ready_o, 1'b0);
                chk1("a_resp_busy",   bus_a.busy_o,  1'b1);
            end
            if (scramble) begin
                bus_a.req_i   = 1'($urandom);
                bus_a.we_i    = 1'($urandom);
                bus_a.addr_i  = $urandom;
                bus_a.wdata_i = $urandom;
            end else begin
                bus_a.req_i = 1'b0;
            end
        end
        step();
        idle_a("a_post");
        bus_a.req_i = 1'b0;
    endtask

    // Store aborted by reset after extra_wait further WAIT cycles; model is left untouched
    task automatic abort_a(input int extra_wait);
        bus_a.req_i   = 1'b1;
        bus_a.we_i    = 1'b1;
        bus_a.addr_i  = 32'h4;
        bus_a.wdata_i = 32'h1111_1111;
        step();
        bus_a.req_i = 1'b0;
        for (int j = 0; j < extra_wait; j++) step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        idle_a("a_abort");
        for (int j = 0; j < 3; j++) begin
            step();
            chk1("a_abort_noack", bus_a.ack_o, 1'b0);
        end
    endtask

    // LATENCY=1 burst with req held high: accept every other cycle, ack the cycle after
    task automatic burst_b(input int n, input bit init);
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bus_b.req_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            we    = init ? 1'b1 : 1'($urandom);
            addr  = init ? 32'(i * 4) : rand_addr();
            wdata = $urandom;
            exp_err   = addr_bad(addr);
            exp_rdata = 32'h0;
            if (!exp_err) begin
                if (we) model_b[int'(addr / 4)] = wdata;
                else    exp_rdata = model_b[int'(addr / 4)];
            end
            bus_b.we_i    = we;
            bus_b.addr_i  = addr;
            bus_b.wdata_i = wdata;
            step();
            chk1("b_resp_ack",    bus_b.ack_o,   1'b1);
            chk1("b_resp_err",    bus_b.err_o,   exp_err);
            chk32("b_resp_rdata", bus_b.rdata_o, exp_rdata);
            chk1("b_resp_ready",  bus_b.ready_o, 1'b0);
            chk1("b_resp_busy",   bus_b.busy_o,  1'b1);
            bus_b.we_i    = 1'($urandom);
            bus_b.addr_i  = $urandom;
            bus_b.wdata_i = $urandom;
            step();
            idle_b("b_gap");
        end
        bus_b.req_i = 1'b0;
    endtask

    initial begin
        bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.wdata_i = '0;
        bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0; bus_b.wdata_i = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset defaults
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle_a("a_reset");
        idle_b("b_reset");
        step();
        idle_a("a_idle_noreq");

        // Fill the array so every later load has a defined value
        for (int i = 0; i < 32; i++) txn_a(1'b1, 32'(i * 4), $urandom, 1'b0);

        // Store/load round trip
        txn_a(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
        txn_a(1'b0, 32'h8, 32'h0, 1'b0);

        // Bad addresses: misaligned load, out-of-range store, word 0 untouched
        txn_a(1'b0, 32'h6, 32'h0, 1'b0);
        txn_a(1'b1, 32'h80, 32'h1234_5678, 1'b0);
        txn_a(1'b0, 32'h0, 32'h0, 1'b0);

        // Bus activity during the busy period is ignored
        for (int i = 0; i < 6; i++) txn_a(1'($urandom), rand_addr(), $urandom, 1'b1);

        // Reset mid-store, both in the first WAIT cycle and on the would-be commit edge
        txn_a(1'b1, 32'h4, 32'hCAFE_F00D, 1'b0);
        abort_a(0);
        txn_a(1'b0, 32'h4, 32'h0, 1'b0);
        abort_a(1);
        txn_a(1'b0, 32'h4, 32'h0, 1'b0);

        // Randomized traffic on the LATENCY=3 instance
        for (int i = 0; i < 60; i++) txn_a(1'($urandom), rand_addr(), $urandom, 1'($urandom));

        // LATENCY=1 back-to-back with req held high
        step();
        idle_b("b_pre");
        burst_b(32, 1'b1);
        burst_b(3, 1'b0);
        step();
        idle_b("b_release");
        burst_b(60, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
